// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-requester register-file write-port arbiter
// Per-requester FIFOs drained round-robin into a registered write port.

module rf_write_arbiter_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_nonempty,
  output logic [W-1:0] o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;

  // Ready depends only on registered count, so a pop never frees space in the same cycle.
  assign o_ready    = i_rst_n && (r_cnt < CW'(DEPTH));
  assign w_push     = i_valid && o_ready;
  assign o_nonempty = (r_cnt != '0);
  assign o_head     = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module rf_write_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_valid,
  output logic          o_a_ready,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic [AW-1:0] o_awr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_we,
  output logic          o_busy
);
  localparam int EW = AW + DW;

  logic          w_a_ne, w_b_ne;
  logic [EW-1:0] w_a_head, w_b_head, w_sel;
  logic          w_grant_a, w_grant_b;
  logic [AW-1:0] w_sel_addr;
  logic          r_last_b;
  logic          r_we;
  logic [AW-1:0] r_awr;
  logic [DW-1:0] r_wr_data;

  rf_write_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_a_valid), .o_ready(o_a_ready),
    .i_data({i_a_addr, i_a_data}), .i_pop(w_grant_a), .o_nonempty(w_a_ne), .o_head(w_a_head)
  );

  rf_write_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_b_valid), .o_ready(o_b_ready),
    .i_data({i_b_addr, i_b_data}), .i_pop(w_grant_b), .o_nonempty(w_b_ne), .o_head(w_b_head)
  );

  // A wins a tie when B was granted last; grants alternate under sustained contention.
  assign w_grant_a  = w_a_ne && (!w_b_ne || r_last_b);
  assign w_grant_b  = w_b_ne && !w_grant_a;
  assign w_sel      = w_grant_a ? w_a_head : w_b_head;
  assign w_sel_addr = w_sel[EW-1:DW];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_b  <= 1'b1;
      r_we      <= 1'b0;
      r_awr     <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_grant_a)      r_last_b <= 1'b0;
      else if (w_grant_b) r_last_b <= 1'b1;
      // Register 0 entries are consumed and count as a grant, but never strobe the port.
      if ((w_grant_a || w_grant_b) && (w_sel_addr != '0)) begin
        r_we      <= 1'b1;
        r_awr     <= w_sel_addr;
        r_wr_data <= w_sel[DW-1:0];
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign o_we      = r_we;
  assign o_awr     = r_awr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = r_we || w_a_ne || w_b_ne;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed vector bench for rf_write_arbiter
module tb_rf_write_arbiter;
  logic        clk;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, awr;
  logic [31:0] a_data, b_data, wr_data;
  logic        we, busy;

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.DW(32), .AW(5), .DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_awr(awr), .o_wr_data(wr_data), .o_we(we), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        we;
    logic [4:0]  awr;
    logic [31:0] wd;
    logic        ar;
    logic        br;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic e_we, logic [4:0] e_awr, logic [31:0] e_wd,
                              logic e_ar, logic e_br, logic e_busy);
    vec_t v;
    v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.we = e_we; v.awr = e_awr; v.wd = e_wd; v.ar = e_ar; v.br = e_br; v.busy = e_busy;
    return v;
  endfunction

  function automatic vec_t idle(logic e_we, logic [4:0] e_awr, logic [31:0] e_wd,
                                logic e_ar, logic e_br, logic e_busy);
    return mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, e_we, e_awr, e_wd, e_ar, e_br, e_busy);
  endfunction

  function automatic vec_t rstv();
    return mk(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [36:0] qa[$], qb[$];
  int          cnt_a, cnt_b, ia, ib;
  logic        acc_a, acc_b, pop_a, pop_b, saw_full_a, saw_full_b;

  task automatic monitor(input bit steady);
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (we) begin
      if (awr[4]) begin
        pop_b = 1'b1;
        if (qb.size() == 0) chk("seq_b_spurious", {27'd0, awr}, 32'd0);
        else begin chk("seq_b_addr", {27'd0, awr}, {27'd0, qb[0][36:32]});
                   chk("seq_b_data", wr_data, qb[0][31:0]); void'(qb.pop_front()); end
      end else begin
        pop_a = 1'b1;
        if (qa.size() == 0) chk("seq_a_spurious", {27'd0, awr}, 32'd0);
        else begin chk("seq_a_addr", {27'd0, awr}, {27'd0, qa[0][36:32]});
                   chk("seq_a_data", wr_data, qa[0][31:0]); void'(qa.pop_front()); end
      end
    end
    cnt_a = cnt_a + int'(acc_a) - int'(pop_a);
    cnt_b = cnt_b + int'(acc_b) - int'(pop_b);
    if (cnt_a == 2) saw_full_a = 1'b1;
    if (cnt_b == 2) saw_full_b = 1'b1;
    chk("seq_a_ready", {31'd0, a_ready}, {31'd0, cnt_a < 2});
    chk("seq_b_ready", {31'd0, b_ready}, {31'd0, cnt_b < 2});
    if (steady) chk("seq_we_sustained", {31'd0, we}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream with one entry queued per side
    tbl.push_back(mk(0, 1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB, 0, 5'd0, 32'd0, 1, 1, 0));
    tbl.push_back(rstv());
    tbl.push_back(idle(0, 5'd0, 32'd0, 1, 1, 0));
    tbl.push_back(idle(0, 5'd0, 32'd0, 1, 1, 0));
    // Single uncontended write
    tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 1, 0));
    tbl.push_back(idle(0, 5'd0, 32'd0, 1, 1, 1));
    tbl.push_back(idle(1, 5'd5, 32'hDEADBEEF, 1, 1, 1));
    tbl.push_back(idle(0, 5'd5, 32'hDEADBEEF, 1, 1, 0));
    // Contention from fresh reset: r1, r3, r2, r4
    tbl.push_back(rstv());
    tbl.push_back(mk(0, 1, 5'd1, 32'h11, 1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5'd2, 32'h22, 1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 1, 1, 1));
    tbl.push_back(idle(1, 5'd1, 32'h11, 1, 0, 1));
    tbl.push_back(idle(1, 5'd3, 32'h33, 1, 1, 1));
    tbl.push_back(idle(1, 5'd2, 32'h22, 1, 1, 1));
    tbl.push_back(idle(1, 5'd4, 32'h44, 1, 1, 1));
    tbl.push_back(idle(0, 5'd4, 32'h44, 1, 1, 0));
    // Register 0 discarded, then B wins the next tie
    tbl.push_back(mk(0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd4, 32'h44, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5'd7, 32'h55, 0, 5'd0, 32'd0, 0, 5'd4, 32'h44, 1, 1, 1));
    tbl.push_back(idle(0, 5'd4, 32'h44, 1, 1, 1));
    tbl.push_back(idle(1, 5'd7, 32'h55, 1, 1, 1));
    tbl.push_back(idle(0, 5'd7, 32'h55, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 0, 5'd7, 32'h55, 1, 1, 0));
    tbl.push_back(idle(0, 5'd7, 32'h55, 1, 1, 1));
    tbl.push_back(idle(1, 5'd9, 32'h99, 1, 1, 1));
    tbl.push_back(idle(1, 5'd8, 32'h88, 1, 1, 1));
    tbl.push_back(idle(0, 5'd8, 32'h88, 1, 1, 0));
    // B back-pressure with 3 entries while A streams
    tbl.push_back(rstv());
    tbl.push_back(mk(0, 1, 5'd16, 32'hA0, 1, 5'd24, 32'hB0, 0, 5'd0, 32'd0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 5'd17, 32'hA1, 1, 5'd25, 32'hB1, 0, 5'd0, 32'd0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 5'd18, 32'hA2, 1, 5'd26, 32'hB2, 1, 5'd16, 32'hA0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 5'd0, 32'd0, 1, 5'd26, 32'hB2, 1, 5'd24, 32'hB0, 0, 1, 1));
    tbl.push_back(idle(1, 5'd17, 32'hA1, 1, 0, 1));
    tbl.push_back(idle(1, 5'd25, 32'hB1, 1, 1, 1));
    tbl.push_back(idle(1, 5'd18, 32'hA2, 1, 1, 1));
    tbl.push_back(idle(1, 5'd26, 32'hB2, 1, 1, 1));
    tbl.push_back(idle(0, 5'd26, 32'hB2, 1, 1, 0));

    foreach (tbl[i]) begin
      rst_n   = !tbl[i].rst;
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      #1;
      chk($sformatf("v%0d_we", i),      {31'd0, we},      {31'd0, tbl[i].we});
      chk($sformatf("v%0d_awr", i),     {27'd0, awr},     {27'd0, tbl[i].awr});
      chk($sformatf("v%0d_wrdata", i),  wr_data,          tbl[i].wd);
      chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ar});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].br});
      chk($sformatf("v%0d_busy", i),    {31'd0, busy},    {31'd0, tbl[i].busy});
      @(posedge clk);
      @(negedge clk);
    end

    // Both sides stream continuously: FIFOs fill, accept one per pop, 1 write/cycle
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cnt_a = 0; cnt_b = 0; ia = 0; ib = 0;
    acc_a = 1'b0; acc_b = 1'b0; saw_full_a = 1'b0; saw_full_b = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      monitor(cyc >= 2);
      a_valid = 1'b1; a_addr = 5'(1 + ia % 15);  a_data = 32'hA000_0000 | 32'(ia);
      b_valid = 1'b1; b_addr = 5'(16 + ib % 15); b_data = 32'hB000_0000 | 32'(ib);
      acc_a = a_ready;
      acc_b = b_ready;
      @(posedge clk);
      if (acc_a) begin qa.push_back({a_addr, a_data}); ia++; end
      if (acc_b) begin qb.push_back({b_addr, b_data}); ib++; end
      @(negedge clk);
      #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      monitor(1'b0);
      acc_a = 1'b0; acc_b = 1'b0;
      @(negedge clk);
      #1;
    end
    chk("seq_a_filled", {31'd0, saw_full_a}, 32'd1);
    chk("seq_b_filled", {31'd0, saw_full_b}, 32'd1);
    chk("seq_a_drained", 32'(qa.size()), 32'd0);
    chk("seq_b_drained", 32'(qb.size()), 32'd0);
    chk("seq_idle_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
